// File: rtl/fp_mul_pack.sv
// Normalize/round/pack stage behind the sequential 24x24 mantissa multiplier (RNE, flush-to-zero).
// Define FP_MUL_FLAGS_EN to add the FLAGS = {NV, OF, UF, NX} output.
module fp_mul_pack #(
    parameter int BIAS = 127,
    parameter int EW   = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDONE,
    input  logic [25:0] PROD,
    input  logic        STICKY_IN,
    input  logic        ACK,
    output logic        BUSY,
    output logic        VALID,
`ifdef FP_MUL_FLAGS_EN
    output logic [3:0]  FLAGS,
`endif
    output logic [31:0] RES
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_NORM, S_ROUND, S_DONE} state_t;
    typedef enum logic [1:0] {C_NUM, C_NAN, C_INF, C_ZERO} cls_t;

    localparam logic signed [EW-1:0] BIAS_E  = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX = EW'(255);
    localparam logic signed [EW-1:0] EXP_MIN = '0;

    state_t               state_q, state_d;
    cls_t                 cls_q, cls_d, cls_in;
    logic                 sign_q, sign_d;
    logic [7:0]           ea_q, ea_d, eb_q, eb_d;
    logic [25:0]          prod_q, prod_d;
    logic                 stky_q, stky_d;
    logic [22:0]          man_q, man_d;
    logic                 g_q, g_d, st_q, st_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [31:0]          res_q, res_d;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]           flags_q, flags_d, pflags;
`endif

    logic a_z, b_z, a_inf, b_inf, a_nan, b_nan;
    assign a_z   = (A[30:23] == 8'h00);
    assign b_z   = (B[30:23] == 8'h00);
    assign a_inf = (A[30:23] == 8'hFF) && (A[22:0] == 23'h0);
    assign b_inf = (B[30:23] == 8'hFF) && (B[22:0] == 23'h0);
    assign a_nan = (A[30:23] == 8'hFF) && (A[22:0] != 23'h0);
    assign b_nan = (B[30:23] == 8'hFF) && (B[22:0] != 23'h0);

    // Subnormal operands are treated as zero, so subnormal x inf is also invalid.
    always_comb begin
        if (a_nan || b_nan || (a_z && b_inf) || (a_inf && b_z)) cls_in = C_NAN;
        else if (a_inf || b_inf)                                 cls_in = C_INF;
        else if (a_z || b_z)                                     cls_in = C_ZERO;
        else                                                     cls_in = C_NUM;
    end

    logic signed [EW-1:0] exp_n, exp_r;
    logic                 rnd_up, m_cy;
    logic [22:0]          man_r;
    logic [31:0]          pack;

    assign exp_n  = EW'(ea_q) + EW'(eb_q) - BIAS_E + EW'(prod_q[25]);
    assign rnd_up = g_q & (st_q | man_q[0]);
    // Mantissa wrap to zero on carry-out is exactly 1.0 at the next exponent.
    assign {m_cy, man_r} = {1'b0, man_q} + 24'(rnd_up);
    assign exp_r  = exp_q + EW'(m_cy);

    always_comb begin
        pack = {sign_q, exp_r[7:0], man_r};
        case (cls_q)
            C_NAN:   pack = 32'h7FC0_0000;
            C_INF:   pack = {sign_q, 8'hFF, 23'h0};
            C_ZERO:  pack = {sign_q, 31'h0};
            default: begin
                if (exp_r >= EXP_MAX)      pack = {sign_q, 8'hFF, 23'h0};
                else if (exp_r <= EXP_MIN) pack = {sign_q, 31'h0};
            end
        endcase
    end

`ifdef FP_MUL_FLAGS_EN
    always_comb begin
        pflags = {3'b000, g_q | st_q};
        case (cls_q)
            C_NAN:   pflags = 4'b1000;
            C_INF:   pflags = 4'b0000;
            C_ZERO:  pflags = 4'b0000;
            default: begin
                if (exp_r >= EXP_MAX)      pflags = 4'b0101;
                else if (exp_r <= EXP_MIN) pflags = 4'b0011;
            end
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        prod_d  = prod_q;
        stky_d  = stky_q;
        man_d   = man_q;
        g_d     = g_q;
        st_d    = st_q;
        exp_d   = exp_q;
        res_d   = res_q;
`ifdef FP_MUL_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            S_IDLE: if (START) begin
                state_d = S_WAIT;
                sign_d  = A[31] ^ B[31];
                ea_d    = A[30:23];
                eb_d    = B[30:23];
                cls_d   = cls_in;
            end
            S_WAIT: if (MDONE) begin
                state_d = S_NORM;
                prod_d  = PROD;
                stky_d  = STICKY_IN;
            end
            S_NORM: begin
                state_d = S_ROUND;
                exp_d   = exp_n;
                if (prod_q[25]) begin
                    man_d = prod_q[24:2];
                    g_d   = prod_q[1];
                    st_d  = prod_q[0] | stky_q;
                end else begin
                    man_d = prod_q[23:1];
                    g_d   = prod_q[0];
                    st_d  = stky_q;
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                res_d   = pack;
`ifdef FP_MUL_FLAGS_EN
                flags_d = pflags;
`endif
            end
            S_DONE: if (ACK) begin
                state_d = S_IDLE;
                res_d   = '0;
`ifdef FP_MUL_FLAGS_EN
                flags_d = '0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cls_q   <= C_NUM;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            prod_q  <= '0;
            stky_q  <= 1'b0;
            man_q   <= '0;
            g_q     <= 1'b0;
            st_q    <= 1'b0;
            exp_q   <= '0;
            res_q   <= '0;
`ifdef FP_MUL_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            prod_q  <= prod_d;
            stky_q  <= stky_d;
            man_q   <= man_d;
            g_q     <= g_d;
            st_q    <= st_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
`ifdef FP_MUL_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign BUSY  = (state_q != S_IDLE);
    assign VALID = (state_q == S_DONE);
    assign RES   = res_q;
`ifdef FP_MUL_FLAGS_EN
    assign FLAGS = flags_q;
`endif

endmodule

// File: tb/tb_fp_mul_pack.sv
// Self-checking bench for fp_mul_pack: directed table, control corner cases, random vs. reference model.
module tb_fp_mul_pack;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0, MDONE = 1'b0, STICKY_IN = 1'b0, ACK = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [25:0] PROD = '0;
    logic        BUSY, VALID;
    logic [31:0] RES;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  FLAGS;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    fp_mul_pack dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .MDONE(MDONE),
        .PROD(PROD), .STICKY_IN(STICKY_IN), .ACK(ACK), .BUSY(BUSY), .VALID(VALID),
`ifdef FP_MUL_FLAGS_EN
        .FLAGS(FLAGS),
`endif
        .RES(RES)
    );

    typedef struct {
        string       nm;
        logic [31:0] a, b;
        logic [25:0] p;
        logic        st;
        int          dly;
        logic [31:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: IEEE single multiply of the given product value, RNE, flush-to-zero.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [25:0] p, input logic st);
        logic   s;
        int     ea, eb, e, sh;
        bit     an, bn, ai, bi, az, bz, g, lost;
        longint pv, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn || (ai && bz) || (az && bi)) return {4'b1000, 32'h7FC00000};
        if (ai || bi) return {4'b0000, s, 8'hFF, 23'h0};
        if (az || bz) return {4'b0000, s, 31'h0};
        pv   = longint'(p);
        sh   = (pv >= (longint'(1) << 25)) ? 2 : 1;
        q    = pv >> sh;
        rem  = pv % (longint'(1) << sh);
        half = longint'(1) << (sh - 1);
        g    = (rem >= half);
        lost = ((rem % half) != 0) || st;
        e    = ea + eb - 127 + sh - 1;
        if (g && (lost || (q % 2 == 1))) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q / 2;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0011, s, 31'h0};
        return {3'b000, g | lost, s, e[7:0], q[22:0]};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [25:0] p,
                         input logic st, input int dly,
                         output logic [31:0] r, output logic [3:0] f, output int lat);
        A = a; B = b; START = 1'b1;
        tick();
        START = 1'b0; A = $urandom; B = $urandom;
        repeat (dly) tick();
        MDONE = 1'b1; PROD = p; STICKY_IN = st;
        tick();
        MDONE = 1'b0; PROD = 26'($urandom); STICKY_IN = 1'($urandom);
        lat = 1;
        while (!VALID && lat < 12) begin
            tick();
            lat++;
        end
        r = RES;
`ifdef FP_MUL_FLAGS_EN
        f = FLAGS;
`else
        f = 4'h0;
`endif
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = $urandom_range(0, 11);
        f = 23'($urandom);
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       begin e = 8'hFF; f = '0; end
            3, 4, 5: e = 8'($urandom_range(1, 254));
            default: e = 8'($urandom_range(90, 164));
        endcase
        return {1'($urandom), e, f};
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [31:0] r, ra, rb;
        logic [3:0]  f;
        logic [35:0] m;
        logic [25:0] p;
        logic        st;
        int          lat;
        bit          stable;

        tbl.push_back('{"mul_1p5",    32'h3FC00000, 32'h3FC00000, 26'h2400000, 1'b0, 24, 32'h40100000});
        tbl.push_back('{"rne_even",   32'h3F800000, 32'h3F800000, 26'h1000001, 1'b0, 2,  32'h3F800000});
        tbl.push_back('{"rne_odd",    32'h3F800000, 32'h3F800000, 26'h1000003, 1'b0, 1,  32'h3F800002});
        tbl.push_back('{"rne_sticky", 32'h3F800000, 32'h3F800000, 26'h1000001, 1'b1, 0,  32'h3F800001});
        tbl.push_back('{"carry_out",  32'h3F800000, 32'h3F800000, 26'h1FFFFFF, 1'b0, 3,  32'h40000000});
        tbl.push_back('{"overflow",   32'h7F000000, 32'h7F000000, 26'h1000000, 1'b0, 2,  32'h7F800000});
        tbl.push_back('{"underflow",  32'h80800000, 32'h00800000, 26'h1000000, 1'b0, 2,  32'h80000000});
        tbl.push_back('{"nan_0xinf",  32'h7F800000, 32'h00000000, 26'h1234567, 1'b0, 1,  32'h7FC00000});
        tbl.push_back('{"nan_op",     32'h7FC00001, 32'h3F800000, 26'h1800000, 1'b1, 4,  32'h7FC00000});
        tbl.push_back('{"inf_op",     32'hFF800000, 32'h40000000, 26'h2000000, 1'b0, 2,  32'hFF800000});
        tbl.push_back('{"zero_op",    32'h00000000, 32'hC0000000, 26'h3FFFFFF, 1'b1, 0,  32'h80000000});

        // Reset state, asserted asynchronously.
        #1 RST = 1'b0;
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_res", RES, 32'h0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        tick();

        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].st, tbl[i].dly, r, f, lat);
            chk({tbl[i].nm, "_lat"}, 32'(lat), 32'd3);
            chk(tbl[i].nm, r, tbl[i].exp);
`ifdef FP_MUL_FLAGS_EN
            m = model(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].st);
            chk({tbl[i].nm, "_flags"}, 32'(f), 32'(m[35:32]));
`endif
            chk({tbl[i].nm, "_idle"}, 32'(BUSY), 32'd0);
        end

        // 1.5 x 1.5 held in DONE for 5 cycles without ACK.
        A = 32'h3FC00000; B = 32'h3FC00000; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (24) tick();
        MDONE = 1'b1; PROD = 26'h2400000; STICKY_IN = 1'b0;
        tick();
        MDONE = 1'b0;
        tick();
        chk("hold_not_yet", 32'(VALID), 32'd0);
        chk("hold_res_zero", RES, 32'h0);
        tick();
        chk("hold_valid", 32'(VALID), 32'd1);
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!(VALID === 1'b1 && RES === 32'h40100000)) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("ack_valid", 32'(VALID), 32'd0);
        chk("ack_res", RES, 32'h0);
        chk("ack_busy", 32'(BUSY), 32'd0);

        // Reset in WAIT.
        A = 32'h3F800000; B = 32'h3F800000; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("wait_busy", 32'(BUSY), 32'd1);
        RST = 1'b0;
        #1;
        chk("wrst_busy", 32'(BUSY), 32'd0);
        chk("wrst_valid", 32'(VALID), 32'd0);
        tick();
        RST = 1'b1;
        MDONE = 1'b1; PROD = 26'h1000000;
        tick();
        MDONE = 1'b0;
        chk("wrst_idle", 32'(BUSY), 32'd0);

        // Reset while in DONE clears RES.
        A = 32'h40000000; B = 32'h40000000; START = 1'b1;
        tick();
        START = 1'b0; MDONE = 1'b1; PROD = 26'h1000000;
        repeat (4) tick();
        MDONE = 1'b0;
        chk("drst_pre", RES, 32'h40800000);
        RST = 1'b0;
        #1;
        chk("drst_res", RES, 32'h0);
        chk("drst_valid", 32'(VALID), 32'd0);
        tick();
        RST = 1'b1;
        tick();

        // START ignored in WAIT and in DONE; START+ACK in DONE goes to IDLE.
        A = 32'h3F800000; B = 32'h3F800000; START = 1'b1;
        tick();
        A = 32'h40000000; B = 32'h40000000;
        tick();
        START = 1'b0;
        MDONE = 1'b1; PROD = 26'h1000000; STICKY_IN = 1'b0;
        tick();
        MDONE = 1'b0;
        repeat (2) tick();
        chk("ign_wait_res", RES, 32'h3F800000);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("ign_done_valid", 32'(VALID), 32'd1);
        chk("ign_done_res", RES, 32'h3F800000);
        START = 1'b1; ACK = 1'b1;
        tick();
        START = 1'b0; ACK = 1'b0;
        chk("start_ack_busy", 32'(BUSY), 32'd0);
        tick();
        chk("start_ack_idle", 32'(BUSY), 32'd0);

        // Random operands against the reference model.
        for (int i = 0; i < 300; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            p  = 26'($urandom_range(32'h1000000, 32'h3FFFFFF));
            st = 1'($urandom);
            m  = model(ra, rb, p, st);
            do_op(ra, rb, p, st, $urandom_range(0, 5), r, f, lat);
            n_chk++;
            if (r !== m[31:0] || lat != 3) begin
                n_fail++;
                $display("FAIL rand A=%h B=%h PROD=%h st=%0d: got %h lat %0d expected %h lat 3",
                         ra, rb, p, st, r, lat, m[31:0]);
            end
`ifdef FP_MUL_FLAGS_EN
            chk("rand_flags", 32'(f), 32'(m[35:32]));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
